// File: rtl/seg_s2p_rx.sv
// Serial-to-parallel display receiver: rebuilds WIDTH-bit frames MSB-first from an async s_clk/s_data/s_en link.
// p_valid rises 3 clk edges after the raw s_clk rise of the last bit; no backpressure, frames are never stalled.
module seg_s2p_rx #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_clk,
  input  logic             s_data,
  input  logic             s_en,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  output logic             frame_err,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  logic [1:0]       r_clk_sync;
  logic [1:0]       r_dat_sync;
  logic [1:0]       r_en_sync;
  logic             r_clk_d3;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_p_out;
  logic             r_p_valid;
  logic             r_frame_err;
  logic [CNT_W-1:0] r_bit_cnt;

  logic             w_rise;
  logic             w_bit;
  logic             w_en;
  logic             w_last;
  logic [WIDTH-1:0] w_next;

  assign w_rise = r_clk_sync[1] & ~r_clk_d3;
  assign w_bit  = r_dat_sync[1];
  assign w_en   = r_en_sync[1];
  assign w_last = (r_bit_cnt == CNT_W'(WIDTH - 1));
  assign w_next = {r_shreg[WIDTH-2:0], w_bit};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_clk_sync  <= 2'b00;
      r_dat_sync  <= 2'b00;
      r_en_sync   <= 2'b00;
      r_clk_d3    <= 1'b0;
      r_shreg     <= '0;
      r_p_out     <= '0;
      r_p_valid   <= 1'b0;
      r_frame_err <= 1'b0;
      r_bit_cnt   <= '0;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], s_clk};
      r_dat_sync  <= {r_dat_sync[0], s_data};
      r_en_sync   <= {r_en_sync[0], s_en};
      r_clk_d3    <= r_clk_sync[1];
      r_p_valid   <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          // A rise coincident with frame start is bit 0; WIDTH>=2 so it is never the last bit.
          if (w_en) begin
            r_state <= SHIFT;
            if (w_rise) begin
              r_shreg   <= w_next;
              r_bit_cnt <= CNT_W'(1);
            end else begin
              r_bit_cnt <= '0;
            end
          end
        end
        SHIFT: begin
          // Enable drop takes priority over a same-cycle rise: the bit is dropped with the frame.
          if (!w_en) begin
            r_state     <= IDLE;
            r_frame_err <= 1'b1;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
          end else if (w_rise) begin
            r_shreg <= w_next;
            if (w_last) begin
              r_p_out   <= w_next;
              r_p_valid <= 1'b1;
              r_bit_cnt <= CNT_W'(WIDTH);
              r_state   <= HOLD;
            end else begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (!w_en) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign p_out     = r_p_out;
  assign p_valid   = r_p_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);
  assign bit_cnt   = r_bit_cnt;

endmodule

// File: tb/tb_seg_s2p_rx.sv
// Bench for seg_s2p_rx: an 8-bit and a 64-bit receiver share one serial driver, steered by sel.
// A frame-level model (count of rises per enable window) predicts words, strobes, errors and latency.
module tb_seg_s2p_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic s_clk_d = 1'b0;
  logic s_data_d = 1'b0;
  logic s_en_d = 1'b0;
  int   cyc = 0;

  logic s_clk8, s_data8, s_en8, s_clk64, s_data64, s_en64;
  logic [7:0]  p_out8;
  logic [63:0] p_out64;
  logic p_valid8, p_valid64, frame_err8, frame_err64, busy8, busy64;
  logic [6:0] bit_cnt8, bit_cnt64;

  assign s_clk8   = ~sel & s_clk_d;
  assign s_data8  = ~sel & s_data_d;
  assign s_en8    = ~sel & s_en_d;
  assign s_clk64  = sel & s_clk_d;
  assign s_data64 = sel & s_data_d;
  assign s_en64   = sel & s_en_d;

  seg_s2p_rx #(.WIDTH(8), .CNT_W(7)) u_dut8 (
    .clk(clk), .rst(rst), .s_clk(s_clk8), .s_data(s_data8), .s_en(s_en8),
    .p_out(p_out8), .p_valid(p_valid8), .frame_err(frame_err8), .busy(busy8), .bit_cnt(bit_cnt8)
  );

  seg_s2p_rx u_dut64 (
    .clk(clk), .rst(rst), .s_clk(s_clk64), .s_data(s_data64), .s_en(s_en64),
    .p_out(p_out64), .p_valid(p_valid64), .frame_err(frame_err64), .busy(busy64), .bit_cnt(bit_cnt64)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Observed strobe activity per receiver (index 0: WIDTH=8, 1: WIDTH=64).
  int v_cnt [2] = '{0, 0};
  int e_cnt [2] = '{0, 0};
  int v_cyc [2] = '{0, 0};

  // Model state.
  logic [63:0] exp_pout [2] = '{64'd0, 64'd0};
  int exp_v [2] = '{0, 0};
  int exp_e [2] = '{0, 0};
  int lat_ref [2] = '{0, 0};
  bit pend_lat [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    if (p_valid8)    begin v_cnt[0]++; v_cyc[0] = cyc; end
    if (p_valid64)   begin v_cnt[1]++; v_cyc[1] = cyc; end
    if (frame_err8)  e_cnt[0]++;
    if (frame_err64) e_cnt[1]++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] obs_pout(input bit s);
    return s ? p_out64 : {56'd0, p_out8};
  endfunction

  function automatic logic [63:0] obs_bcnt(input bit s);
    return s ? {57'd0, bit_cnt64} : {57'd0, bit_cnt8};
  endfunction

  function automatic logic [63:0] obs_busy(input bit s);
    return s ? {63'd0, busy64} : {63'd0, busy8};
  endfunction

  task automatic prev_check(input bit s, input bit chk_busy);
    @(negedge clk);
    chk("p_out", obs_pout(s), exp_pout[s]);
    chk("valid_cnt", v_cnt[s], exp_v[s]);
    chk("err_cnt", e_cnt[s], exp_e[s]);
    if (pend_lat[s]) begin
      chk("latency", v_cyc[s] - lat_ref[s], 3);
      pend_lat[s] = 1'b0;
    end
    if (chk_busy) chk("busy_idle", obs_busy(s), 0);
  endtask

  task automatic settle(input bit s);
    repeat (8) @(posedge clk);
    prev_check(s, 1'b1);
  endtask

  // One s_clk period of 8 clk: data set 4 clk before the rise, held 4 clk after it.
  task automatic shift_bit(input logic b, input bit drop_en, output int rise_cyc);
    @(posedge clk); #1;
    s_clk_d = 1'b0;
    s_data_d = b;
    repeat (4) @(posedge clk);
    #1;
    s_clk_d = 1'b1;
    if (drop_en) s_en_d = 1'b0;
    rise_cyc = cyc;
    repeat (3) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; s_en_d = 1'b0; s_clk_d = 1'b0; s_data_d = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_p_out8", obs_pout(1'b0), 0);
    chk("rst_bcnt8", obs_bcnt(1'b0), 0);
    chk("rst_busy8", obs_busy(1'b0), 0);
    chk("rst_p_out64", obs_pout(1'b1), 0);
    chk("rst_bcnt64", obs_bcnt(1'b1), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_pout[0] = 64'd0;
    exp_pout[1] = 64'd0;
    pend_lat[0] = 1'b0;
    pend_lat[1] = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  // Sends n bits (word[n-1] first) in one enable window; coinc drops s_en on the last rise.
  task automatic frame(input bit s, input logic [63:0] word, input int n, input bit coinc, input int gap);
    int w, eff, rc;
    logic [63:0] mask;
    w = s ? 64 : 8;
    @(posedge clk); #1;
    sel = s;
    s_en_d = 1'b1;
    repeat (4) @(posedge clk);
    prev_check(s, 1'b0);
    chk("start_bcnt", obs_bcnt(s), 0);
    for (int i = 0; i < n; i++) begin
      shift_bit(word[n-1-i], coinc && (i == n - 1), rc);
      if (i == w - 1 && !(coinc && i == n - 1)) lat_ref[s] = rc;
    end
    @(posedge clk); #1;
    s_clk_d = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    if (!coinc) begin
      chk("frame_bcnt", obs_bcnt(s), (n < w) ? n : w);
      chk("frame_busy", obs_busy(s), 1);
    end
    @(posedge clk); #1;
    s_en_d = 1'b0;
    repeat (gap) @(posedge clk);
    eff = coinc ? n - 1 : n;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    if (eff >= w) begin
      exp_pout[s] = (word >> (n - w)) & mask;
      exp_v[s]++;
      pend_lat[s] = 1'b1;
    end else begin
      exp_e[s]++;
      pend_lat[s] = 1'b0;
    end
  endtask

  initial begin
    int rc, n;
    logic [63:0] rw;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("init_p_out8", obs_pout(1'b0), 0);
    chk("init_valid8", {63'd0, p_valid8}, 0);
    chk("init_err8", {63'd0, frame_err8}, 0);
    chk("init_busy8", obs_busy(1'b0), 0);
    chk("init_bcnt8", obs_bcnt(1'b0), 0);
    chk("init_p_out64", obs_pout(1'b1), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);

    frame(1'b0, 64'hA5, 8, 1'b0, 6);
    settle(1'b0);

    frame(1'b0, 64'h3C, 8, 1'b0, 6);
    frame(1'b0, 64'h15, 5, 1'b0, 6);
    settle(1'b0);

    frame(1'b0, 64'h40F, 11, 1'b0, 6);
    settle(1'b0);

    // Reset lands after 4 bits of a frame.
    @(posedge clk); #1;
    sel = 1'b0;
    s_en_d = 1'b1;
    for (int i = 0; i < 4; i++) shift_bit(i[0], 1'b0, rc);
    do_reset();
    frame(1'b0, 64'h5A, 8, 1'b0, 6);
    settle(1'b0);

    // Serial clock activity with enable low is ignored.
    do_reset();
    @(posedge clk); #1;
    sel = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i % 4 == 0) begin
        s_clk_d = ~s_clk_d;
        s_data_d = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    s_clk_d = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("idle_bcnt", obs_bcnt(1'b0), 0);
    settle(1'b0);
    frame(1'b0, 64'($urandom), 6, 1'b1, 6);
    settle(1'b0);

    frame(1'b1, 64'h0123456789ABCDEF, 64, 1'b0, 2);
    frame(1'b1, 64'hFFFFFFFF00000000, 64, 1'b0, 6);
    settle(1'b1);

    for (int k = 0; k < 8; k++) begin
      rw = {$urandom, $urandom};
      n = $urandom_range(3, 11);
      frame(1'b0, rw, n, 1'($urandom_range(0, 1)), $urandom_range(4, 8));
    end
    settle(1'b0);

    rw = {$urandom, $urandom};
    frame(1'b1, rw, 64, 1'b0, 6);
    n = $urandom_range(20, 63);
    frame(1'b1, {$urandom, $urandom}, n, 1'b0, 6);
    settle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg_s2p_rx.md
Name: seg_s2p_rx

Overview:
- Serial-to-parallel receiver: the receiving end of the segment-display serial link driven by the P2S shifter.
- Samples an external serial clock, data and enable, all asynchronous to clk, and rebuilds WIDTH-bit display frames MSB-first.
- Presents each complete frame on a parallel output with a one-cycle valid strobe.
- Used as a loopback checker and as the display-side model in the SEGP2S subsystem.

Parameters:
- WIDTH, 64, bits per frame (8 digits x 8 segments); legal range 2..64.
- CNT_W, 7, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- s_clk  input  1  serial shift clock, async to clk; data taken on its rising edge.
- s_data  input  1  serial data; first bit received becomes p_out[WIDTH-1].
- s_en  input  1  frame enable; high for the whole frame, async to clk.
- p_out  output  WIDTH  last complete frame, held until the next complete frame.
- p_valid  output  1  one-cycle pulse when p_out is updated.
- frame_err  output  1  one-cycle pulse when a frame is aborted short.
- busy  output  1  high while in SHIFT or HOLD.
- bit_cnt  output  CNT_W  bits received in the current frame.

Behaviour:
- Reset, synchronous and active-high: state=IDLE, shift register=0, p_out=0, bit_cnt=0, p_valid=0, frame_err=0, busy=0, synchronizer flops=0.
- Reset asserted mid-frame discards the partial frame; p_out returns to 0.
- Synchronization: s_clk, s_data and s_en each pass through two flops (sync2), plus a third s_clk flop (sync3) for edge detection.
- rise = s_clk sync2 & ~sync3. s_data is sampled from its sync2 at the same cycle.
- Data must be stable from at least 3 clk before to 3 clk after the s_clk rise.
- s_clk high and low times must each be at least 3 clk periods; shorter pulses give undefined results.
- State IDLE:
  - Enter SHIFT when en_s (sync2 of s_en) is high; clear bit_cnt on entry.
  - A rise in the same cycle as the IDLE->SHIFT transition is captured as bit 0.
  - All rises while en_s is low are ignored.
- State SHIFT:
  - On rise: shreg <= {shreg[WIDTH-2:0], bit}; bit_cnt += 1.
  - If bit_cnt==WIDTH-1 at that rise: p_out <= {shreg[WIDTH-2:0], bit}, p_valid=1 next cycle, bit_cnt <= WIDTH, go to HOLD.
  - If en_s falls before WIDTH bits: frame_err=1 for one cycle, p_out unchanged, shreg cleared, go to IDLE.
  - If a rise and the en_s fall occur in the same cycle: the fall wins; the bit is discarded and the error is flagged.
- State HOLD:
  - Ignore further rises, with no overflow flag.
  - Go to IDLE when en_s is low; bit_cnt holds at WIDTH until then.
  - Cleared to 0 on the next frame start.
- Latency: p_valid rises on the 3rd clk edge after the raw s_clk rise carrying the last bit. The 2 sync stages plus 1 edge/shift stage make this 3 edges.
- p_out and p_valid change on the same edge.
- Back-to-back frames need en_s low for at least 1 sampled cycle between them. A continuously high s_en yields exactly one frame.
- busy = (state != IDLE).

Test Plan:
- WIDTH=8: rst for 2 cycles, then s_en=1, shift 0xA5 MSB-first (s_clk period 8 clk), s_en=0 -> p_out=0xA5, exactly one p_valid pulse 3 clk after the 8th raw rise, frame_err never set, bit_cnt=8 then 0 after the next frame starts.
- WIDTH=64 default: frame 0x0123456789ABCDEF followed by frame 0xFFFFFFFF00000000 with a 2-cycle s_en gap -> two p_valid pulses with the correct words; p_out holds the first word until the second strobe.
- WIDTH=8, send 0x3C, then a frame with only 5 bits and s_en dropped -> frame_err single pulse, no p_valid, p_out stays 0x3C, state IDLE, busy=0.
- WIDTH=8, 11 s_clk rises inside one s_en window, data 0x81 followed by 1,1,1 -> p_out=0x81, one p_valid, extra rises ignored, no error.
- WIDTH=8, rst asserted after 4 bits, released, full frame 0x5A sent -> during rst p_out=0 and bit_cnt=0; afterwards p_out=0x5A with no frame_err.
- s_clk toggling with s_en=0 for 50 cycles -> bit_cnt=0, busy=0, no pulses; then the en_s fall coincident with the 6th rise -> frame_err, bit discarded.
